// File: rtl/iter_div_unit_if.sv
// Handshake and result bundle between the control FSM and the iterative divider.
// The master launches operations; the slave (divider) returns status and results.
interface iter_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed or unsigned.
// Signed operands are divided as magnitudes; signs are fixed up when the result is loaded.
module iter_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    iter_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_pr;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_pr_next;
    logic [WIDTH-1:0] w_dsr_next;
    logic             w_last;

    function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // One restoring step: shift, trial subtract, keep or restore.
    always_comb begin
        w_shift    = {r_pr, r_dsr[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_dvs};
        w_qbit     = ~w_diff[WIDTH];
        w_pr_next  = w_shift[WIDTH-1:0];
        if (w_qbit) begin
            w_pr_next = w_diff[WIDTH-1:0];
        end else begin
            w_pr_next = w_shift[WIDTH-1:0];
        end
        w_dsr_next = {r_dsr[WIDTH-2:0], w_qbit};
        w_last     = (r_count == CW'(WIDTH-1));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dsr    <= '0;
            r_dvs    <= '0;
            r_pr     <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            r_state  <= S_RUN;
                            r_busy   <= 1'b1;
                            r_dsr    <= f_cond_neg(bus.dividend, bus.is_signed & bus.dividend[WIDTH-1]);
                            r_dvs    <= f_cond_neg(bus.divisor, bus.is_signed & bus.divisor[WIDTH-1]);
                            r_sign_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            r_sign_r <= bus.is_signed & bus.dividend[WIDTH-1];
                            r_pr     <= '0;
                            r_count  <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_quot  <= '0;
                            r_rem   <= bus.dividend;
                            r_dbz   <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_pr    <= w_pr_next;
                    r_dsr   <= w_dsr_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= f_cond_neg(w_dsr_next, r_sign_q);
                        r_rem   <= f_cond_neg(w_pr_next, r_sign_r);
                        r_dbz   <= 1'b0;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Multicycle iterative integer divider in the execute datapath, directly downstream of the main control FSM.
- The FSM's div_op strobe launches an operation. The unit performs radix-2 restoring division, one quotient bit per cycle.
- While the unit is busy, the control FSM holds in its execute state. The result goes to the ALU result mux and is written back on done.
- Supports unsigned (UDIV) and signed (SDIV) operation.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be ≥ 4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- start  input  1  launch request; driven by div_op from the control FSM.
- is_signed  input  1  1 = signed two's-complement divide, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  numerator (Rn); sampled with start.
- divisor  input  WIDTH  denominator (Rm); sampled with start.
- busy  output  1  high while iterating; FSM must stall while high.
- done  output  1  single-cycle pulse; quotient/remainder valid from this cycle.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag; high if the last operation had divisor == 0.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - State goes to IDLE; busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0.
  - The iteration counter and internal registers are cleared.
  - Reset overrides start and aborts any operation in progress with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start == 1 with divisor != 0 → RUN.
    - Latch |dividend| and |divisor|. Magnitudes are taken only if is_signed; otherwise raw values.
    - Latch sign_q = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) and sign_r = is_signed & dividend[WIDTH-1].
    - Clear the partial remainder; counter = 0.
  - start == 1 with divisor == 0 → DONE directly.
    - Load quotient = 0, remainder = dividend (raw), div_by_zero = 1.
  - start == 0 → stay in IDLE. Outputs hold their last values.
- RUN:
  - busy = 1.
  - Each cycle:
    - Shift {partial remainder, dividend shift register} left by 1.
    - Trial-subtract the divisor magnitude from the (WIDTH+1)-bit partial remainder.
    - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments each cycle. After exactly WIDTH RUN cycles → DONE.
  - Sign correction is applied on that transition: quotient = sign_q ? −Q : Q, remainder = sign_r ? −R : R, computed modulo 2^WIDTH. Registers are loaded; div_by_zero = 0.
- DONE:
  - done = 1, busy = 0 for one cycle, then → IDLE unconditionally.
- Latency:
  - The start-sampled cycle is cycle 0.
  - Normal case: busy high in cycles 1..WIDTH; done high in cycle WIDTH+1.
  - Divide-by-zero case: done in cycle 1; busy never asserts.
- start handling:
  - start is ignored in RUN and DONE; no queuing.
  - Operand inputs are ignored except in the cycle start is accepted.
  - Back-to-back: start asserted in the DONE cycle is dropped. The next start is accepted in the following IDLE cycle, giving a minimum spacing of WIDTH+2 cycles.
- Signed overflow: signed MIN / −1 is not special-cased. Magnitude arithmetic yields quotient = MIN (bit pattern 100…0) and remainder = 0, with no flag.
- Result holding: quotient, remainder and div_by_zero change only on entry to DONE or on reset.
- Invariant (divisor != 0): dividend == quotient*divisor + remainder mod 2^WIDTH. |remainder| < |divisor|. A non-zero remainder has the dividend's sign (signed mode).

Test Plan:
- Reset, then unsigned 100 / 7 → busy high cycles 1..32; done in cycle 33 only; quotient = 14, remainder = 2, div_by_zero = 0.
- Signed −100 (0xFFFFFF9C) / 7 → quotient = 0xFFFFFFF2 (−14), remainder = 0xFFFFFFFE (−2). Signed 100 / −7 → quotient = 0xFFFFFFF2, remainder = 2.
- Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0. Unsigned 0xFFFFFFFF / 1 → quotient = 0xFFFFFFFF, remainder = 0.
- Divide by zero, unsigned 5 / 0 → busy never high; done in cycle 1; quotient = 0, remainder = 5, div_by_zero = 1. A following 9 / 3 clears div_by_zero and gives quotient = 3, remainder = 0.
- Launch 1000 / 10, then pulse start with 7 / 7 at cycles 5 and 33 (the DONE cycle) → both ignored; result quotient = 100, remainder = 0; exactly one done pulse.
- Launch 50 / 3, drive reset = 0 at cycle 10 for one edge → busy = 0, quotient = remainder = 0, no done. A new start at cycle 12 completes normally with quotient = 16, remainder = 2.
